// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry adder with carry-in/carry-out, plus a one-cycle
// registered copy of the result qualified by a valid flag.

module full_adder_cell (
   input  logic a,
   input  logic b,
   input  logic c_in,
   output logic s,
   output logic c_out
);

   assign s     = a ^ b ^ c_in;
   assign c_out = (a & b) | (a & c_in) | (b & c_in);

endmodule

module full_adder #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             C_IN,
   input  logic             IN_VALID,
   output logic             C_OUT,
   output logic [WIDTH-1:0] S,
   output logic [WIDTH-1:0] S_REG,
   output logic             C_OUT_REG,
   output logic             OUT_VALID
);

   // carry[i] feeds bit i; carry[WIDTH] is the unsigned carry-out.
   logic [WIDTH:0] carry;

   assign carry[0] = C_IN;
   assign C_OUT    = carry[WIDTH];

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      full_adder_cell u_cell (
         .a     (A[i]),
         .b     (B[i]),
         .c_in  (carry[i]),
         .s     (S[i]),
         .c_out (carry[i+1])
      );
   end

   // NOTE: non-blocking assignments keep every register sampling the
   // pre-edge values; the async reset must appear in the sensitivity list.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         S_REG     <= '0;
         C_OUT_REG <= 1'b0;
         OUT_VALID <= 1'b0;
      end else begin
         OUT_VALID <= IN_VALID;
         // Result registers hold across invalid cycles; only valid flag drops.
         if (IN_VALID) begin
            S_REG     <= S;
            C_OUT_REG <= C_OUT;
         end
      end
   end

endmodule

// File: tb/tb_full_adder.sv
// Directed and random checks of full_adder at WIDTH=1, 8 and 16: combinational
// sum/carry, registered latency, async reset and streaming.

module tb_full_adder;

   logic clk;
   logic rst;

   int pass_cnt  = 0;
   int total_cnt = 0;

   // WIDTH=1 instance
   logic a1, b1, c1, v1, co1, s1, sr1, cor1, ov1;
   // WIDTH=8 instance
   logic [7:0] a8, b8, s8, sr8;
   logic       c8, v8, co8, cor8, ov8;
   // WIDTH=16 instance
   logic [15:0] a16, b16, s16, sr16;
   logic        c16, v16, co16, cor16, ov16;

   full_adder #(.WIDTH(1)) dut1 (
      .clk(clk), .rst(rst), .A(a1), .B(b1), .C_IN(c1), .IN_VALID(v1),
      .C_OUT(co1), .S(s1), .S_REG(sr1), .C_OUT_REG(cor1), .OUT_VALID(ov1)
   );

   full_adder #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .A(a8), .B(b8), .C_IN(c8), .IN_VALID(v8),
      .C_OUT(co8), .S(s8), .S_REG(sr8), .C_OUT_REG(cor8), .OUT_VALID(ov8)
   );

   full_adder #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .A(a16), .B(b16), .C_IN(c16), .IN_VALID(v16),
      .C_OUT(co16), .S(s16), .S_REG(sr16), .C_OUT_REG(cor16), .OUT_VALID(ov16)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic test_reset();
      #1 rst = 1'b1;
      #2;
      total_cnt++;
      if ({sr8, cor8, ov8} !== 10'h000)
         $display("FAIL reset_w8: got %h expected %h", {sr8, cor8, ov8}, 10'h000);
      else pass_cnt++;
      total_cnt++;
      if ({sr16, cor16, ov16} !== 18'h00000)
         $display("FAIL reset_w16: got %h expected %h", {sr16, cor16, ov16}, 18'h00000);
      else pass_cnt++;
      // Held through a clock edge even with valid input present.
      v8 = 1'b1; a8 = 8'h05; b8 = 8'h06; c8 = 1'b0;
      @(posedge clk); #1;
      total_cnt++;
      if ({sr8, cor8, ov8} !== 10'h000)
         $display("FAIL reset_hold: got %h expected %h", {sr8, cor8, ov8}, 10'h000);
      else pass_cnt++;
      total_cnt++;
      if ({co8, s8} !== 9'h00B)
         $display("FAIL reset_comb: got %h expected %h", {co8, s8}, 9'h00B);
      else pass_cnt++;
      v8 = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_truth_table();
      logic [1:0] tt [8];
      logic [2:0] idx;
      tt = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
      for (int i = 0; i < 8; i++) begin
         idx = 3'(i);
         a1 = idx[2]; b1 = idx[1]; c1 = idx[0];
         #1;
         total_cnt++;
         if ({co1, s1} !== tt[i])
            $display("FAIL truth_%0d: got %b expected %b", i, {co1, s1}, tt[i]);
         else pass_cnt++;
         #9;
      end
   endtask

   task automatic test_boundary();
      logic [7:0] va [3];
      logic [7:0] vb [3];
      logic       vc [3];
      logic [8:0] ve [3];
      va = '{8'hFF, 8'hFF, 8'h00};
      vb = '{8'h01, 8'hFF, 8'h00};
      vc = '{1'b0, 1'b1, 1'b0};
      ve = '{9'h100, 9'h1FF, 9'h000};
      for (int i = 0; i < 3; i++) begin
         a8 = va[i]; b8 = vb[i]; c8 = vc[i];
         #1;
         total_cnt++;
         if ({co8, s8} !== ve[i])
            $display("FAIL boundary_%0d: got %h expected %h", i, {co8, s8}, ve[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_latency();
      @(negedge clk);
      a8 = 8'h12; b8 = 8'h34; c8 = 1'b1; v8 = 1'b1;
      @(posedge clk); #1;
      total_cnt++;
      if ({sr8, cor8, ov8} !== {8'h47, 1'b0, 1'b1})
         $display("FAIL latency_capture: got %h expected %h", {sr8, cor8, ov8}, {8'h47, 1'b0, 1'b1});
      else pass_cnt++;
      v8 = 1'b0; a8 = 8'hF0; b8 = 8'h20;
      @(posedge clk); #1;
      total_cnt++;
      if ({sr8, cor8, ov8} !== {8'h47, 1'b0, 1'b0})
         $display("FAIL latency_hold: got %h expected %h", {sr8, cor8, ov8}, {8'h47, 1'b0, 1'b0});
      else pass_cnt++;
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      a8 = 8'hC0; b8 = 8'h50; c8 = 1'b1; v8 = 1'b1;
      @(posedge clk); #1;
      total_cnt++;
      if ({sr8, cor8, ov8} !== {8'h11, 1'b1, 1'b1})
         $display("FAIL async_pre: got %h expected %h", {sr8, cor8, ov8}, {8'h11, 1'b1, 1'b1});
      else pass_cnt++;
      #2 rst = 1'b1;
      #1;
      total_cnt++;
      if ({sr8, cor8, ov8} !== 10'h000)
         $display("FAIL async_clear: got %h expected %h", {sr8, cor8, ov8}, 10'h000);
      else pass_cnt++;
      a8 = 8'h0F; b8 = 8'h01; c8 = 1'b0;
      #1;
      total_cnt++;
      if ({co8, s8} !== 9'h010)
         $display("FAIL async_comb: got %h expected %h", {co8, s8}, 9'h010);
      else pass_cnt++;
      @(negedge clk);
      rst = 1'b0;
      v8 = 1'b0;
   endtask

   task automatic test_streaming();
      logic [7:0] va [4];
      logic [7:0] vb [4];
      logic       vc [4];
      logic [9:0] ve [4];
      va = '{8'd1, 8'd3, 8'd200, 8'd255};
      vb = '{8'd2, 8'd4, 8'd100, 8'd0};
      vc = '{1'b0, 1'b1, 1'b0, 1'b1};
      // {S_REG, C_OUT_REG, OUT_VALID}
      ve = '{{8'd3, 1'b0, 1'b1}, {8'd8, 1'b0, 1'b1},
             {8'd44, 1'b1, 1'b1}, {8'd0, 1'b1, 1'b1}};
      @(negedge clk);
      a8 = va[0]; b8 = vb[0]; c8 = vc[0]; v8 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         total_cnt++;
         if ({sr8, cor8, ov8} !== ve[i])
            $display("FAIL stream_%0d: got %h expected %h", i, {sr8, cor8, ov8}, ve[i]);
         else pass_cnt++;
         if (i < 3) begin
            a8 = va[i+1]; b8 = vb[i+1]; c8 = vc[i+1];
         end else begin
            v8 = 1'b0;
         end
      end
      @(posedge clk); #1;
      total_cnt++;
      if (ov8 !== 1'b0)
         $display("FAIL stream_end: got %b expected %b", ov8, 1'b0);
      else pass_cnt++;
   endtask

   task automatic test_random();
      logic [16:0] exp_sum;
      int          bad_comb = 0;
      int          bad_reg  = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         a16 = 16'($urandom);
         b16 = 16'($urandom);
         c16 = 1'($urandom);
         v16 = 1'b1;
         exp_sum = {1'b0, a16} + {1'b0, b16} + {16'd0, c16};
         #1;
         total_cnt++;
         if ({co16, s16} !== exp_sum) begin
            if (bad_comb < 5)
               $display("FAIL rand_comb_%0d: got %h expected %h", i, {co16, s16}, exp_sum);
            bad_comb++;
         end else pass_cnt++;
         @(posedge clk); #1;
         total_cnt++;
         if ({cor16, sr16, ov16} !== {exp_sum, 1'b1}) begin
            if (bad_reg < 5)
               $display("FAIL rand_reg_%0d: got %h expected %h", i, {cor16, sr16, ov16}, {exp_sum, 1'b1});
            bad_reg++;
         end else pass_cnt++;
      end
      v16 = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      a1 = 1'b0; b1 = 1'b0; c1 = 1'b0; v1 = 1'b0;
      a8 = '0; b8 = '0; c8 = 1'b0; v8 = 1'b0;
      a16 = '0; b16 = '0; c16 = 1'b0; v16 = 1'b0;

      test_reset();
      test_truth_table();
      test_boundary();
      test_latency();
      test_async_reset();
      test_streaming();
      test_random();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/full_adder.md
Name: full_adder

Overview:
- WIDTH-bit binary adder with carry-in and carry-out.
- Default WIDTH=1 gives the classic 1-bit full adder.
- Provides a purely combinational sum/carry path plus a one-cycle registered copy with a valid flag, for use in pipelined datapaths.
- Leaf arithmetic block; instantiated by datapath and ALU-level modules.

Parameters:
- WIDTH, 1, operand and sum width in bits (legal range 1..64).

Ports:
- clk  input  1  rising-edge clock for the registered stage.
- rst  input  1  asynchronous, active-high reset of the registered stage.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- C_IN  input  1  carry-in.
- IN_VALID  input  1  qualifies A/B/C_IN for capture into the registered stage.
- C_OUT  output  1  combinational carry-out.
- S  output  WIDTH  combinational sum.
- S_REG  output  WIDTH  registered sum.
- C_OUT_REG  output  1  registered carry-out.
- OUT_VALID  output  1  registered-stage valid.

Behaviour:
- Combinational path:
  - {C_OUT, S} = A + B + C_IN, computed at WIDTH+1 bits; zero latency.
  - Unaffected by clk and rst.
- For WIDTH=1 the path must match this truth table (A B C_IN -> C_OUT S):
  - 000->00, 001->01, 010->01, 011->10
  - 100->01, 101->10, 110->10, 111->11
- Implementation: ripple of 1-bit full-adder cells.
  - Cell: s_i = a_i ^ b_i ^ c_i; c_(i+1) = a_i&b_i | a_i&c_i | b_i&c_i; c_0 = C_IN; C_OUT = c_WIDTH.
- No overflow or wrap flag: C_OUT is the unsigned carry.
  - Example: all-ones + all-ones + 1 gives S = all-ones, C_OUT = 1.
- X/undriven inputs propagate to the combinational outputs; no X-masking.
- Registered stage, on rising clk:
  - If IN_VALID=1: S_REG <= S, C_OUT_REG <= C_OUT, OUT_VALID <= 1.
  - If IN_VALID=0: S_REG and C_OUT_REG hold; OUT_VALID <= 0.
  - Latency from a valid input to a valid registered result: exactly 1 cycle.
  - Back-to-back valid inputs produce back-to-back valid outputs; no stall.
- Reset:
  - rst=1 immediately (asynchronously) forces S_REG=0, C_OUT_REG=0, OUT_VALID=0, independent of clk.
  - All three are held at 0 while rst is asserted.
  - The first capture occurs on the first rising clk with rst=0 and IN_VALID=1.
  - Reset asserted mid-stream discards the in-flight result; the combinational outputs keep tracking the inputs throughout.
- No internal state other than the three output registers.

Test Plan:
- WIDTH=1 exhaustive: step A,B,C_IN through 000..111 at 10 ns intervals -> C_OUT,S = 00,01,01,10,01,10,10,11 within the same delta.
- WIDTH=8 boundary: A=8'hFF, B=8'h01, C_IN=0 -> S=8'h00, C_OUT=1; A=8'hFF, B=8'hFF, C_IN=1 -> S=8'hFF, C_OUT=1; A=0, B=0, C_IN=0 -> S=0, C_OUT=0.
- Registered latency, WIDTH=8: IN_VALID=1 with A=8'h12, B=8'h34, C_IN=1 for one cycle -> next edge S_REG=8'h47, C_OUT_REG=0, OUT_VALID=1; following edge with IN_VALID=0 -> OUT_VALID=0, S_REG still 8'h47.
- Async reset: assert rst between clock edges while OUT_VALID=1 -> S_REG, C_OUT_REG, OUT_VALID go to 0 before the next edge; combinational S/C_OUT keep reflecting the inputs.
- Streaming: IN_VALID=1 for 4 consecutive cycles with (A,B,C_IN) = (1,2,0), (3,4,1), (200,100,0), (255,0,1) -> OUT_VALID=1 for 4 cycles with S_REG = 3, 8, 44 (C_OUT_REG=1), 0 (C_OUT_REG=1), in order.
- Random: 1000 random WIDTH=16 vectors -> {C_OUT,S} equals the 17-bit reference sum; registered copy equals it one cycle later.
